// File: rtl/itch_msg_pkg.sv
// itch_msg_pkg: ITCH 5.0 message types, frame lengths and packed layouts.
// msg_len maps a type byte to its frame length (0 = unsupported type).
package itch_msg_pkg;

  localparam int unsigned MSG_W = 320;

  typedef enum logic [7:0] {
    MT_SYS      = 8'h53,
    MT_DIR      = 8'h52,
    MT_ADD      = 8'h41,
    MT_ADD_MPID = 8'h46,
    MT_EXEC     = 8'h45,
    MT_EXEC_PX  = 8'h43,
    MT_CANCEL   = 8'h58,
    MT_DELETE   = 8'h44,
    MT_REPLACE  = 8'h55
  } msg_type_e;

  localparam logic [5:0] LEN_S = 6'd12;
  localparam logic [5:0] LEN_R = 6'd39;
  localparam logic [5:0] LEN_A = 6'd36;
  localparam logic [5:0] LEN_F = 6'd40;
  localparam logic [5:0] LEN_E = 6'd31;
  localparam logic [5:0] LEN_C = 6'd36;
  localparam logic [5:0] LEN_X = 6'd23;
  localparam logic [5:0] LEN_D = 6'd19;
  localparam logic [5:0] LEN_U = 6'd35;

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [15:0] stock_locate;
    logic [15:0] tracking_num;
    logic [47:0] timestamp;
  } itch_hdr_t;

  typedef struct packed {
    itch_hdr_t  hdr;
    logic [7:0] event_code;
  } itch_sys_t;

  typedef struct packed {
    itch_hdr_t   hdr;
    logic [63:0] stock;
    logic [7:0]  market_category;
    logic [7:0]  financial_status;
    logic [31:0] round_lot_size;
    logic [7:0]  round_lots_only;
    logic [7:0]  issue_classification;
    logic [15:0] issue_sub_type;
    logic [7:0]  authenticity;
    logic [7:0]  short_sale_threshold;
    logic [7:0]  ipo_flag;
    logic [7:0]  luld_ref_tier;
    logic [7:0]  etp_flag;
    logic [31:0] ETP_leverage_factor;
    logic [7:0]  inverse_indicator;
  } itch_dir_t;

  typedef struct packed {
    itch_hdr_t   hdr;
    logic [63:0] order_ref;
    logic [7:0]  side;
    logic [31:0] shares;
    logic [63:0] stock;
    logic [31:0] price;
  } itch_add_t;

  typedef struct packed {
    itch_hdr_t   hdr;
    logic [63:0] order_ref;
    logic [7:0]  side;
    logic [31:0] shares;
    logic [63:0] stock;
    logic [31:0] price;
    logic [31:0] attribution;
  } itch_add_mpid_t;

  typedef struct packed {
    itch_hdr_t   hdr;
    logic [63:0] order_ref;
    logic [31:0] executed_shares;
    logic [63:0] match_num;
  } itch_exec_t;

  typedef struct packed {
    itch_hdr_t   hdr;
    logic [63:0] order_ref;
    logic [31:0] executed_shares;
    logic [63:0] match_num;
    logic [7:0]  printable;
    logic [31:0] exec_price;
  } itch_exec_px_t;

  typedef struct packed {
    itch_hdr_t   hdr;
    logic [63:0] order_ref;
    logic [31:0] cancelled_shares;
  } itch_cancel_t;

  typedef struct packed {
    itch_hdr_t   hdr;
    logic [63:0] order_ref;
  } itch_delete_t;

  typedef struct packed {
    itch_hdr_t   hdr;
    logic [63:0] orig_order_ref;
    logic [63:0] new_order_ref;
    logic [31:0] shares;
    logic [31:0] price;
  } itch_replace_t;

  function automatic logic [5:0] msg_len(input logic [7:0] t);
    logic [5:0] l;
    l = 6'd0;
    case (t)
      MT_SYS:      l = LEN_S;
      MT_DIR:      l = LEN_R;
      MT_ADD:      l = LEN_A;
      MT_ADD_MPID: l = LEN_F;
      MT_EXEC:     l = LEN_E;
      MT_EXEC_PX:  l = LEN_C;
      MT_CANCEL:   l = LEN_X;
      MT_DELETE:   l = LEN_D;
      MT_REPLACE:  l = LEN_U;
      default:     l = 6'd0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/itch_msg_serializer.sv
// itch_msg_serializer: emits whole ITCH 5.0 messages as a byte stream.
// Define ITCH_LEN_PREFIX_EN to prepend a 2-byte big-endian length.
// Ports: clk, rst_n (async, active-low);
//   in_valid/in_ready/in_msg[319:0] message in, type byte at [319:312];
//   out_valid/out_ready/out_data/out_first/out_last byte stream out;
//   err_unknown one-cycle pulse on a dropped type; msg_count frames sent.
module itch_msg_serializer
  import itch_msg_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] in_msg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_first,
  output logic         out_last,
  output logic         err_unknown,
  output logic [31:0]  msg_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef ITCH_LEN_PREFIX_EN
    LEN_HI = 2'd1,
    LEN_LO = 2'd2,
`endif
    BODY   = 2'd3
  } state_e;

  state_e       state_q;
  logic [319:0] sr_q;
  logic [5:0]   len_q;
  logic [5:0]   byte_idx_q;
  logic         init_q;
  logic         out_valid_q;
  logic         out_first_q;
  logic         out_last_q;
  logic [7:0]   out_data_q;
  logic         err_q;
  logic [31:0]  cnt_q;
  logic [31:0]  cnt_d;

  logic       xfer;
  logic       last_xfer;
  logic       acc;
  logic [5:0] in_len;
  logic       known;

  assign xfer      = out_valid_q && out_ready;
  assign last_xfer = xfer && out_last_q;
  // init_q keeps in_ready low until the first edge after reset
  assign in_ready  = init_q && ((state_q == IDLE) || last_xfer);
  assign acc       = in_valid && in_ready;
  assign in_len    = msg_len(in_msg[319:312]);
  assign known     = (in_len != 6'd0);
  assign cnt_d     = cnt_q + 32'd1;

  assign out_valid   = out_valid_q;
  assign out_first   = out_first_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign err_unknown = err_q;
  assign msg_count   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      len_q       <= '0;
      byte_idx_q  <= '0;
      init_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      init_q <= 1'b1;
      err_q  <= 1'b0;
      if (last_xfer) cnt_q <= cnt_d;
      if (acc) begin
        if (known) begin
          sr_q        <= in_msg;
          len_q       <= in_len;
          byte_idx_q  <= '0;
          out_valid_q <= 1'b1;
          out_first_q <= 1'b1;
          out_last_q  <= 1'b0;
`ifdef ITCH_LEN_PREFIX_EN
          state_q     <= LEN_HI;
          // lengths never exceed 40, so the high byte is always zero
          out_data_q  <= 8'h00;
`else
          state_q     <= BODY;
          out_data_q  <= in_msg[319:312];
`endif
        end else begin
          err_q       <= 1'b1;
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_first_q <= 1'b0;
          out_last_q  <= 1'b0;
          out_data_q  <= '0;
        end
      end else if (xfer) begin
        unique case (state_q)
`ifdef ITCH_LEN_PREFIX_EN
          LEN_HI: begin
            state_q     <= LEN_LO;
            out_data_q  <= {2'b00, len_q};
            out_first_q <= 1'b0;
          end
          LEN_LO: begin
            state_q    <= BODY;
            out_data_q <= sr_q[319:312];
          end
`endif
          BODY: begin
            out_first_q <= 1'b0;
            if (out_last_q) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
            end else begin
              sr_q       <= {sr_q[311:0], 8'h00};
              byte_idx_q <= byte_idx_q + 6'd1;
              out_data_q <= sr_q[311:304];
              // next byte index is byte_idx+1; last when it reaches len-1
              out_last_q <= ((byte_idx_q + 6'd2) == len_q);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_itch_msg_serializer.sv
// tb_itch_msg_serializer: random + directed stimulus against a
// byte-queue reference model of the serializer.
module tb_itch_msg_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [319:0] in_msg = '0;
  logic         in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_first;
  logic         out_last;
  logic         err_unknown;
  logic [31:0]  msg_count;

  typedef struct {
    logic [7:0] d;
    bit         f;
    bit         l;
  } beat_t;

  beat_t       q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_xfer = 0;
  bit          live = 0;
  bit          err_exp = 0;
  bit          last_acc = 0;
  logic [31:0] cnt_exp = 0;
  int          pre = 0;

  itch_msg_serializer dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_msg(in_msg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_first(out_first),
    .out_last(out_last),
    .err_unknown(err_unknown),
    .msg_count(msg_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_len(input logic [7:0] t);
    case (t)
      8'h53: return 12;
      8'h52: return 39;
      8'h41: return 36;
      8'h46: return 40;
      8'h45: return 31;
      8'h43: return 36;
      8'h58: return 23;
      8'h44: return 19;
      8'h55: return 35;
      default: return 0;
    endcase
  endfunction

  function automatic void push_frame(input logic [319:0] m);
    logic [7:0] fr[$];
    beat_t      b;
    int         len;
    len = ref_len(m[319:312]);
`ifdef ITCH_LEN_PREFIX_EN
    fr.push_back(8'(len >> 8));
    fr.push_back(8'(len));
`endif
    for (int i = 0; i < len; i++) fr.push_back(m[319-8*i -: 8]);
    for (int i = 0; i < fr.size(); i++) begin
      b.d = fr[i];
      b.f = (i == 0);
      b.l = (i == fr.size() - 1);
      q.push_back(b);
    end
  endfunction

  function automatic logic [319:0] rand_msg(input logic [7:0] t);
    logic [319:0] m;
    for (int i = 0; i < 10; i++) m[32*i +: 32] = $urandom;
    m[319:312] = t;
    return m;
  endfunction

  // one clock: check outputs vs model, then advance the model
  task automatic cyc();
    bit m_rdy;
    bit m_acc;
    bit m_xfer;
    #1;
    m_rdy = live && ((q.size() == 0) ||
                     (q.size() == 1 && out_ready));
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_first", out_first, q[0].f);
      chk("out_last", out_last, q[0].l);
    end
    chk("err_unknown", err_unknown, err_exp);
    chk("msg_count", msg_count, cnt_exp);
    m_acc  = in_valid && m_rdy;
    m_xfer = (q.size() != 0) && out_ready;
    @(posedge clk);
    live     = 1;
    err_exp  = 0;
    last_acc = m_acc;
    if (m_xfer) begin
      if (q[0].l) cnt_exp = cnt_exp + 1;
      void'(q.pop_front());
      n_xfer++;
    end
    if (m_acc) begin
      if (ref_len(in_msg[319:312]) == 0) err_exp = 1;
      else push_frame(in_msg);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [319:0] m, input bit keep);
    bit ok;
    ok = 0;
    in_msg   = m;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      cyc();
      ok = last_acc;
    end
    if (!keep) in_valid = 1'b0;
    chk("send_timeout", ok, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && q.size() != 0; i++) cyc();
    cyc();
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_first"}, out_first, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_err"}, err_unknown, 0);
    chk({tag, "_count"}, msg_count, 0);
    chk({tag, "_ready"}, in_ready, 0);
  endtask

  logic [7:0] types[10] = '{8'h53, 8'h52, 8'h41, 8'h46, 8'h45,
                            8'h43, 8'h58, 8'h44, 8'h55, 8'h5A};

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [319:0] m;
    int base;
`ifdef ITCH_LEN_PREFIX_EN
    pre = 2;
`endif
    #12;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // "D" with a known order reference
    m = '0;
    m[319:312] = 8'h44;
    m[231:168] = 64'h0102030405060708;
    out_ready = 1'b1;
    base = n_xfer;
    send(m, 0);
    drain();
    chk("d_bytes", n_xfer - base, 19 + pre);
    chk("d_count", msg_count, 1);

    // back-to-back A then X, in_valid held
    base = n_xfer;
    send(rand_msg(8'h41), 1);
    send(rand_msg(8'h58), 0);
    drain();
    chk("b2b_bytes", n_xfer - base, 59 + 2 * pre);
    chk("b2b_count", msg_count, 3);

    // backpressure on byte 6 of S
    base = n_xfer;
    send(rand_msg(8'h53), 0);
    for (int i = 0; i < 50 && n_xfer < base + 6; i++) cyc();
    out_ready = 1'b0;
    repeat (5) cyc();
    chk("bp_held", n_xfer - base, 6);
    drain();
    chk("bp_bytes", n_xfer - base, 12 + pre);

    // unknown type
    send(rand_msg(8'h5A), 0);
    cyc();
    cyc();
    chk("unk_count", msg_count, 4);

    // F frame
    base = n_xfer;
    send(rand_msg(8'h46), 0);
    drain();
    chk("f_bytes", n_xfer - base, 40 + pre);

    // reset in the middle of a U frame
    base = n_xfer;
    send(rand_msg(8'h55), 0);
    for (int i = 0; i < 50 && n_xfer < base + 10; i++) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    q.delete();
    cnt_exp = 0;
    err_exp = 0;
    live = 0;
    @(negedge clk);
    rst_n = 1'b1;
    base = n_xfer;
    send(rand_msg(8'h45), 0);
    drain();
    chk("e_bytes", n_xfer - base, 31 + pre);
    chk("e_count", msg_count, 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) != 0)
        in_msg = rand_msg(types[$urandom_range(0, 9)]);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
